// File: rtl/score_arbiter.sv
// Two-player score keeper: round-robin req/ack arbiter over one shared saturating add datapath.
// Define SCORE_ARB_WIN_EN to compile in win detection and the OVER lock-out state.
`timescale 1ns/1ps
module score_arbiter #(
    parameter int WIN_SCORE = 20,
    parameter int MAX_SCORE = 99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        req_1,
    input  logic [3:0]  pts_1,
    input  logic        req_2,
    input  logic [3:0]  pts_2,
    output logic        ack_1,
    output logic        ack_2,
    output logic [15:0] score_1,
    output logic [15:0] score_2,
    output logic        win_1,
    output logic        win_2,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_CHECK = 2'd2
`ifdef SCORE_ARB_WIN_EN
        , S_OVER = 2'd3
`endif
    } state_t;

    localparam logic [7:0] MAX_S8 = 8'(MAX_SCORE);
    localparam logic [6:0] MAX_S7 = 7'(MAX_SCORE);

    state_t      state_q, state_d;
    logic        prio2_q, prio2_d;
    logic        sel_q, sel_d;
    logic [3:0]  addend_q, addend_d;
    logic [6:0]  score1_q, score1_d;
    logic [6:0]  score2_q, score2_d;
    logic        ack1_q, ack1_d;
    logic        ack2_q, ack2_d;
    logic        busy_q, busy_d;
    logic        grant2;
    logic [6:0]  cur;
    logic [7:0]  sum;
    logic [6:0]  sat;

    assign cur = sel_q ? score2_q : score1_q;
    // 8-bit sum: 99 + 15 cannot overflow before the clamp
    assign sum = {1'b0, cur} + {4'b0000, addend_q};
    assign sat = (sum > MAX_S8) ? MAX_S7 : sum[6:0];

`ifdef SCORE_ARB_WIN_EN
    localparam logic [15:0] WIN_S = 16'(WIN_SCORE);
    logic win1_q, win1_d, win2_q, win2_d, over_q, over_d;
`endif

    always_comb begin
        state_d  = state_q;
        prio2_d  = prio2_q;
        sel_d    = sel_q;
        addend_d = addend_q;
        score1_d = score1_q;
        score2_d = score2_q;
        ack1_d   = 1'b0;
        ack2_d   = 1'b0;
        grant2   = 1'b0;
`ifdef SCORE_ARB_WIN_EN
        win1_d   = win1_q;
        win2_d   = win2_q;
        over_d   = over_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_1 || req_2) begin
                    grant2   = req_2 && (!req_1 || prio2_q);
                    sel_d    = grant2;
                    addend_d = grant2 ? pts_2 : pts_1;
                    ack1_d   = !grant2;
                    ack2_d   = grant2;
                    prio2_d  = !grant2;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                if (sel_q) score2_d = sat;
                else       score1_d = sat;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_IDLE;
`ifdef SCORE_ARB_WIN_EN
                if ({9'b0, cur} >= WIN_S) begin
                    if (sel_q) win2_d = 1'b1;
                    else       win1_d = 1'b1;
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end
`endif
            end
`ifdef SCORE_ARB_WIN_EN
            S_OVER: state_d = S_OVER;
`endif
            default: state_d = S_IDLE;
        endcase
        // New game drops any in-flight addend and restores player 1 priority
        if (clear) begin
            state_d  = S_IDLE;
            prio2_d  = 1'b0;
            score1_d = '0;
            score2_d = '0;
            ack1_d   = 1'b0;
            ack2_d   = 1'b0;
`ifdef SCORE_ARB_WIN_EN
            win1_d   = 1'b0;
            win2_d   = 1'b0;
            over_d   = 1'b0;
`endif
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prio2_q  <= 1'b0;
            score1_q <= '0;
            score2_q <= '0;
            ack1_q   <= 1'b0;
            ack2_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio2_q  <= prio2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            ack1_q   <= ack1_d;
            ack2_q   <= ack2_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        sel_q    <= sel_d;
        addend_q <= addend_d;
    end

`ifdef SCORE_ARB_WIN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win1_q <= 1'b0;
            win2_q <= 1'b0;
            over_q <= 1'b0;
        end else begin
            win1_q <= win1_d;
            win2_q <= win2_d;
            over_q <= over_d;
        end
    end
    assign win_1     = win1_q;
    assign win_2     = win2_q;
    assign game_over = over_q;
`else
    assign win_1     = 1'b0;
    assign win_2     = 1'b0;
    assign game_over = 1'b0;
`endif

    assign ack_1   = ack1_q;
    assign ack_2   = ack2_q;
    assign score_1 = {9'b0, score1_q};
    assign score_2 = {9'b0, score2_q};
    assign busy    = busy_q;

endmodule

// File: tb/tb_score_arbiter.sv
// Self-checking bench for score_arbiter: vector table, hand-written corner sequences and
// randomized transactions against a transaction-level score model.
`timescale 1ns/1ps
module tb_score_arbiter;

    localparam int WIN = 20;
    localparam int MAX = 99;

    logic        clk = 1'b0;
    logic        rst_n, clear, req_1, req_2;
    logic [3:0]  pts_1, pts_2;
    logic        ack_1, ack_2, win_1, win_2, game_over, busy;
    logic [15:0] score_1, score_2;

    score_arbiter #(.WIN_SCORE(WIN), .MAX_SCORE(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_1(req_1), .pts_1(pts_1), .req_2(req_2), .pts_2(pts_2),
        .ack_1(ack_1), .ack_2(ack_2), .score_1(score_1), .score_2(score_2),
        .win_1(win_1), .win_2(win_2), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       r1;
        logic [3:0] p1;
        logic       r2;
        logic [3:0] p2;
        logic       a1;
        logic       a2;
        int         s1;
        int         s2;
    } vec_t;

    vec_t tbl[8];

    // transaction-level reference state
    int m_s[2];
    int m_win[2];
    int m_last;
    int m_over;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_s[0] = 0; m_s[1] = 0; m_win[0] = 0; m_win[1] = 0;
        m_last = 2; m_over = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        chk("clear_score_1", score_1, 0);
        chk("clear_score_2", score_2, 0);
    endtask

    // Single-requester grant: ack next cycle, score the cycle after
    task automatic grant_one(input int p, input logic [3:0] pts, input int exp_score);
        if (p == 1) begin req_1 = 1'b1; pts_1 = pts; end
        else        begin req_2 = 1'b1; pts_2 = pts; end
        tick();
        chk("g_ack_1", ack_1, (p == 1));
        chk("g_ack_2", ack_2, (p == 2));
        req_1 = 1'b0; req_2 = 1'b0;
        tick();
        chk("g_score", (p == 1) ? score_1 : score_2, exp_score);
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0,  3,  0};
        tbl[1] = '{1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 1'b1,  3,  4};
        tbl[2] = '{1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0,  5,  4};
        tbl[3] = '{1'b1, 4'd1, 1'b1, 4'd6, 1'b0, 1'b1,  5, 10};
        tbl[4] = '{1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0,  5, 10};
        tbl[5] = '{1'b1, 4'd7, 1'b1, 4'd1, 1'b0, 1'b1,  5, 11};
        tbl[6] = '{1'b1, 4'd7, 1'b1, 4'd1, 1'b1, 1'b0, 12, 11};
        tbl[7] = '{1'b0, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 12, 11};

        // reset overrides clear and requests
        rst_n = 1'b0; clear = 1'b1;
        req_1 = 1'b1; req_2 = 1'b1; pts_1 = 4'd5; pts_2 = 4'd5;
        tick(); tick();
        chk("rst_score_1", score_1, 0);
        chk("rst_score_2", score_2, 0);
        chk("rst_ack_1", ack_1, 0);
        chk("rst_ack_2", ack_2, 0);
        chk("rst_win_1", win_1, 0);
        chk("rst_win_2", win_2, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1; clear = 1'b0; req_1 = 1'b0; req_2 = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            req_1 = tbl[i].r1; pts_1 = tbl[i].p1;
            req_2 = tbl[i].r2; pts_2 = tbl[i].p2;
            tick();
            chk("tbl_ack_1", ack_1, tbl[i].a1);
            chk("tbl_ack_2", ack_2, tbl[i].a2);
            chk("tbl_busy", busy, tbl[i].a1 | tbl[i].a2);
            req_1 = 1'b0; req_2 = 1'b0;
            tick();
            chk("tbl_ack_1_pulse", ack_1, 0);
            chk("tbl_ack_2_pulse", ack_2, 0);
            chk("tbl_score_1", score_1, tbl[i].s1);
            chk("tbl_score_2", score_2, tbl[i].s2);
            tick();
            chk("tbl_busy_done", busy, 0);
        end

        // both requesters held: grants every 3 cycles alternating 1,2,1,2
        do_clear();
        req_1 = 1'b1; req_2 = 1'b1; pts_1 = 4'd1; pts_2 = 4'd1;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("rr_ack_1", ack_1, (t == 0) || (t == 6));
            chk("rr_ack_2", ack_2, (t == 3) || (t == 9));
        end
        req_1 = 1'b0; req_2 = 1'b0;
        chk("rr_score_1", score_1, 2);
        chk("rr_score_2", score_2, 2);
        chk("rr_busy", busy, 0);

        // clear during ADD discards the addend and restores player 1 priority
        do_clear();
        req_1 = 1'b1; pts_1 = 4'd7;
        tick();
        chk("cadd_ack_1", ack_1, 1);
        req_1 = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cadd_score_1", score_1, 0);
        chk("cadd_busy", busy, 0);
        chk("cadd_ack_1_low", ack_1, 0);
        req_1 = 1'b1; req_2 = 1'b1; pts_1 = 4'd1; pts_2 = 4'd1;
        tick();
        chk("cadd_next_ack_1", ack_1, 1);
        chk("cadd_next_ack_2", ack_2, 0);
        req_1 = 1'b0; req_2 = 1'b0;
        tick(); tick();
        chk("cadd_next_score_1", score_1, 1);

`ifdef SCORE_ARB_WIN_EN
        do_clear();
        grant_one(2, 4'd15, 15);
        grant_one(2, 4'd3, 18);
        chk("pre_win_2", win_2, 0);
        grant_one(2, 4'd2, 20);
        chk("win_2", win_2, 1);
        chk("win_1", win_1, 0);
        chk("win_game_over", game_over, 1);
        chk("win_busy", busy, 1);
        req_1 = 1'b1; req_2 = 1'b1; pts_1 = 4'd5; pts_2 = 4'd5;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("over_ack_1", ack_1, 0);
            chk("over_ack_2", ack_2, 0);
        end
        req_1 = 1'b0; req_2 = 1'b0;
        chk("over_score_1", score_1, 0);
        chk("over_score_2", score_2, 20);
        do_clear();
        chk("over_clr_win_2", win_2, 0);
        chk("over_clr_game_over", game_over, 0);
        chk("over_clr_busy", busy, 0);
        grant_one(1, 4'd4, 4);
`else
        do_clear();
        for (int k = 0; k < 6; k++) grant_one(1, 4'd15, 15 * (k + 1));
        grant_one(1, 4'd7, 97);
        grant_one(1, 4'd5, 99);
        grant_one(1, 4'd15, 99);
        chk("sat_score_2", score_2, 0);
        chk("sat_win_1", win_1, 0);
        chk("sat_game_over", game_over, 0);
        chk("sat_busy", busy, 0);
`endif

        // randomized transactions against the score model
        do_clear();
        for (int i = 0; i < 60; i++) begin
            int pat, g, pa, pb;
            if (($urandom % 8) == 0) begin
                do_clear();
                continue;
            end
            if (m_over != 0) begin
                req_1 = 1'b1; req_2 = 1'b1;
                tick();
                chk("rnd_over_ack_1", ack_1, 0);
                chk("rnd_over_ack_2", ack_2, 0);
                chk("rnd_over_busy", busy, 1);
                req_1 = 1'b0; req_2 = 1'b0;
                do_clear();
                continue;
            end
            pat = $urandom_range(0, 2);
            pa  = $urandom_range(0, 15);
            pb  = $urandom_range(0, 15);
            req_1 = (pat != 1); req_2 = (pat != 0);
            pts_1 = 4'(pa); pts_2 = 4'(pb);
            if (pat == 2) g = (m_last == 1) ? 2 : 1;
            else          g = (pat == 0) ? 1 : 2;
            tick();
            chk("rnd_ack_1", ack_1, (g == 1));
            chk("rnd_ack_2", ack_2, (g == 2));
            req_1 = 1'b0; req_2 = 1'b0;
            m_last = g;
            m_s[g-1] = m_s[g-1] + ((g == 1) ? pa : pb);
            if (m_s[g-1] > MAX) m_s[g-1] = MAX;
            tick();
            chk("rnd_score_1", score_1, m_s[0]);
            chk("rnd_score_2", score_2, m_s[1]);
`ifdef SCORE_ARB_WIN_EN
            if (m_s[g-1] >= WIN) begin
                m_over = 1;
                m_win[g-1] = 1;
            end
`endif
            tick();
            chk("rnd_win_1", win_1, m_win[0]);
            chk("rnd_win_2", win_2, m_win[1]);
            chk("rnd_game_over", game_over, m_over);
            chk("rnd_busy", busy, m_over);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_arbiter.md
# score_arbiter

Two-player score keeper and update arbiter feeding the 8-digit score display. Both game-logic requesters share a single add-and-check datapath through a req/ack handshake with round-robin priority. The block holds the authoritative binary scores that drive the display's `score_1`/`score_2` inputs. It also detects the winning condition and freezes scoring until a new game is started.

## Interface
Parameters:
- `WIN_SCORE`, default 20: score at or above which a player wins.
- `MAX_SCORE`, default 99: saturation ceiling. Must be ≤ 99 because the display shows two digits.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `clear` in 1: new game. Synchronous; priority over all except `rst_n`.
- `req_1` in 1: player 1 add request. Level; held until `ack_1`.
- `pts_1` in 4: points for player 1. Valid while `req_1`=1.
- `req_2` in 1: player 2 add request.
- `pts_2` in 4: points for player 2.
- `ack_1` out 1: one-cycle grant pulse to player 1.
- `ack_2` out 1: one-cycle grant pulse to player 2.
- `score_1` out 16: player 1 score, binary. Bits [15:7] are always 0.
- `score_2` out 16: player 2 score, binary.
- `win_1` out 1: player 1 won. Sticky until `clear` or reset.
- `win_2` out 1: player 2 won.
- `game_over` out 1: `win_1 | win_2`, registered.
- `busy` out 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, ADD, CHECK, OVER. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Select a requester. If only one requests, grant it. If both request, grant the one not granted last (round-robin pointer).
  - Latch the granted player's `pts_x` into the addend register and the player index into the select register.
  - Assert `ack_x` for exactly one cycle, toggle the pointer, and go to ADD.
- ADD: `score_x <= min(score_x + addend, MAX_SCORE)`. Compute in 8 bits so no overflow is possible. Go to CHECK.
- CHECK: if `score_x >= WIN_SCORE`, set `win_x` and `game_over`, then go to OVER. Otherwise go to IDLE.
- OVER: requests are ignored and no ack is issued. Scores hold. Stay in OVER until `clear`.
- `clear` in any state:
  - Scores, `win_x` and `game_over` go to 0.
  - The pointer is reset so player 1 has priority.
  - The FSM goes to IDLE and any in-flight addend is discarded.
  - No ack is asserted that cycle.
- `pts_x = 0` is legal: the request is granted, the score is unchanged, and the win check still runs.
- Requester rule: deassert `req_x` in the cycle after `ack_x`=1. Requests are sampled only in IDLE, so a req still high two cycles later counts as a new request.

## Timing
- Reset values: `score_1` = `score_2` = 0, `ack_1` = `ack_2` = 0, `win_1` = `win_2` = 0, `game_over` = 0, `busy` = 0. State is IDLE and the pointer favours player 1.
- Cycle 0 is the first rising edge at which the request is sampled in IDLE.
- Request seen at edge N:
  - `ack_x` is high in cycle N+1 and `busy` goes high.
  - The score updates at edge N+2 (visible in cycle N+2).
  - `win_x` and `game_over` update at edge N+3.
  - The FSM is back in IDLE in cycle N+3, or in OVER on a win.
- Throughput: one grant per 3 cycles. Under simultaneous continuous requests, grants alternate 1, 2, 1, 2…
- `rst_n` low at an edge overrides `clear` and all requests.
- `clear` and a request at the same edge: the clear wins and the request is sampled at the next IDLE edge.

## Configuration
- Macro `SCORE_ARB_WIN_EN`.
- Defined: win detection and the OVER state are compiled in, as described above.
- Undefined:
  - CHECK always returns to IDLE and the OVER state is absent.
  - `win_1`, `win_2` and `game_over` are tied to 0.
  - Scores only saturate at `MAX_SCORE`, and requests are always serviced.

## Test plan
- Reset, then `req_1`=1 with `pts_1`=3 until ack → `ack_1` pulses one cycle after the request is seen; `score_1`=3 two cycles after the request; `score_2`=0; `busy` returns low.
- `req_1` and `req_2` both held with `pts`=1 for 4 grants → ack order 1, 2, 1, 2; both scores = 2; grants are 3 cycles apart.
- `score_1`=97, `MAX_SCORE`=99, `WIN_SCORE`=200 (macro undefined), add 5 → `score_1`=99 with no wrap.
- With the macro defined, `score_2`=18 and `WIN_SCORE`=20, add 2 → `win_2`=1 and `game_over`=1. Further requests get no ack and scores hold. `clear` → all zero and requests are serviced again.
- `clear` asserted in the ADD cycle of a `pts_1`=7 grant → `score_1` stays 0, the FSM is in IDLE next cycle, and the next simultaneous request grants player 1.
